// File: rtl/calc_pkg.sv
// calc_pkg: op codes shared by the sequencer and the ALU control decode,
// sequencer state encodings and small decode helpers.
// Related build macro: CALC_STICKY_OVF_EN (used by calc_acc_reg).
package calc_pkg;

  // Command / ALU operation codes. CMD_LOAD and CMD_NOP never reach the ALU.
  typedef enum logic [2:0] {
    CMD_LOAD = 3'b000,
    CMD_NOP  = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101,
    ALU_NOR  = 3'b110,
    ALU_XOR  = 3'b111
  } op_e;

  // Sequencer states: one command outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Latency counter width; covers ALU_LAT up to 15.
  localparam int LAT_W = 4;

  // Only ADD and SUB produce a meaningful signed-overflow flag.
  function automatic logic is_arith(input op_e op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // Any op that is dispatched to the ALU (everything except LOAD and NOP).
  function automatic logic uses_alu(input op_e op);
    return (op != CMD_LOAD) && (op != CMD_NOP);
  endfunction

endpackage

// File: rtl/calc_acc_reg.sv
// calc_acc_reg: accumulator and overflow flag for the calculator sequencer.
// The FSM supplies mutually exclusive load / capture / nop enables.
// Build macro: CALC_STICKY_OVF_EN -- when defined the overflow flag is the
// OR of every ADD/SUB overflow since reset or the last LOAD; otherwise it
// reflects only the most recent command.
module calc_acc_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             cap_en,
  input  logic [WIDTH-1:0] cap_val,
  input  logic             cap_ovf,
  input  logic             nop_en,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

`ifdef CALC_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  // Next accumulator / overflow value from the FSM enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_en) begin
      acc_d = load_val;
      ovf_d = 1'b0;
    end else if (cap_en) begin
      acc_d = cap_val;
      ovf_d = STICKY ? (ovf_q | cap_ovf) : cap_ovf;
    end else if (nop_en) begin
      ovf_d = STICKY ? ovf_q : 1'b0;
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: one-command-at-a-time sequencer around an external ALU.
// IDLE accepts a command, EXEC drives the ALU for ALU_LAT cycles and captures
// its result, DONE presents the accumulator until the consumer takes it.
// Build macro: CALC_STICKY_OVF_EN selects sticky overflow (see calc_acc_reg).
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_ovf
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT);

  state_e           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;

  logic             load_en, cap_en, nop_en, cap_ovf;
  logic [WIDTH-1:0] acc;
  logic             ovf;

  // Next-state, command latch, accumulator enables and ALU drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    imm_d       = imm_q;
    load_en     = 1'b0;
    cap_en      = 1'b0;
    nop_en      = 1'b0;
    alu_A       = '0;
    alu_B       = '0;
    alu_control = 3'b000;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d  = op_e'(cmd_op);
          imm_d = cmd_imm;
          if (op_e'(cmd_op) == CMD_LOAD) begin
            load_en = 1'b1;
            state_d = ST_DONE;
          end else if (op_e'(cmd_op) == CMD_NOP) begin
            nop_en  = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = LAT_INIT;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        // Operands are taken from registers only, so they stay stable for the whole state.
        alu_A       = acc;
        alu_B       = imm_q;
        alu_control = op_q;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == LAT_W'(1)) begin
          cap_en  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Overflow is meaningful only for ADD/SUB; logic ops report 0.
  assign cap_ovf = alu_overflow & is_arith(op_q);

  // FSM state, latency counter and latched command.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= CMD_LOAD;
      imm_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
    end
  end

  calc_acc_reg #(
    .WIDTH(WIDTH)
  ) u_acc (
    .clock   (clock),
    .reset   (reset),
    .load_en (load_en),
    .load_val(cmd_imm),
    .cap_en  (cap_en),
    .cap_val (alu_out),
    .cap_ovf (cap_ovf),
    .nop_en  (nop_en),
    .acc     (acc),
    .ovf     (ovf)
  );

  // Handshake flags decode registered state only.
  assign cmd_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_data  = acc;
  assign res_zero  = (acc == '0);
  assign res_ovf   = ovf;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed checks of calc_sequencer with ALU_LAT=1 (u1)
// and ALU_LAT=3 (u3). A behavioural ALU closes the loop for each instance.
module tb_calc_sequencer;

  logic clock;
  logic reset;

  logic        cmd_valid1, cmd_ready1, res_valid1, res_ready1, res_zero1, res_ovf1;
  logic [2:0]  cmd_op1, alu_ctl1;
  logic [31:0] cmd_imm1, alu_A1, alu_B1, alu_out1, res_data1;
  logic        alu_ovf1;

  logic        cmd_valid3, cmd_ready3, res_valid3, res_ready3, res_zero3, res_ovf3;
  logic [2:0]  cmd_op3, alu_ctl3;
  logic [31:0] cmd_imm3, alu_A3, alu_B3, alu_out3, res_data3;
  logic        alu_ovf3;

  int n_chk = 0;
  int n_err = 0;

`ifdef CALC_STICKY_OVF_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  localparam logic [2:0] OP_LOAD = 3'b000, OP_NOP = 3'b001, OP_ADD = 3'b010,
                         OP_SUB = 3'b011, OP_AND = 3'b100, OP_OR = 3'b101,
                         OP_NOR = 3'b110, OP_XOR = 3'b111;

  // Behavioural 32-bit ALU: {overflow, result}.
  function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] c);
    logic [31:0] r;
    logic        ov;
    r  = '0;
    ov = 1'b0;
    case (c)
      OP_ADD: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_XOR: r = a ^ b;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  assign {alu_ovf1, alu_out1} = alu(alu_A1, alu_B1, alu_ctl1);
  assign {alu_ovf3, alu_out3} = alu(alu_A3, alu_B3, alu_ctl3);

  calc_sequencer #(.WIDTH(32), .ALU_LAT(1)) u1 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1), .cmd_imm(cmd_imm1),
    .alu_A(alu_A1), .alu_B(alu_B1), .alu_control(alu_ctl1),
    .alu_out(alu_out1), .alu_overflow(alu_ovf1),
    .res_valid(res_valid1), .res_ready(res_ready1), .res_data(res_data1),
    .res_zero(res_zero1), .res_ovf(res_ovf1)
  );

  calc_sequencer #(.WIDTH(32), .ALU_LAT(3)) u3 (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op3), .cmd_imm(cmd_imm3),
    .alu_A(alu_A3), .alu_B(alu_B3), .alu_control(alu_ctl3),
    .alu_out(alu_out3), .alu_overflow(alu_ovf3),
    .res_valid(res_valid3), .res_ready(res_ready3), .res_data(res_data3),
    .res_zero(res_zero3), .res_ovf(res_ovf3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a command to u1 for one handshake cycle (u1 must be in IDLE).
  task automatic send1(input logic [2:0] op, input logic [31:0] imm);
    check("u1 cmd_ready before send", {31'd0, cmd_ready1}, 32'd1);
    cmd_valid1 = 1'b1;
    cmd_op1    = op;
    cmd_imm1   = imm;
    step();
    cmd_valid1 = 1'b0;
  endtask

  task automatic send3(input logic [2:0] op, input logic [31:0] imm);
    check("u3 cmd_ready before send", {31'd0, cmd_ready3}, 32'd1);
    cmd_valid3 = 1'b1;
    cmd_op3    = op;
    cmd_imm3   = imm;
    step();
    cmd_valid3 = 1'b0;
  endtask

  // Check a u1 result in DONE, then let it return to IDLE.
  task automatic result1(input string tag, input logic [31:0] data, input logic ovf);
    check({tag, " res_valid"}, {31'd0, res_valid1}, 32'd1);
    check({tag, " res_data"},  res_data1, data);
    check({tag, " res_zero"},  {31'd0, res_zero1}, {31'd0, (data == 32'd0)});
    check({tag, " res_ovf"},   {31'd0, res_ovf1}, {31'd0, ovf});
    check({tag, " cmd_ready"}, {31'd0, cmd_ready1}, 32'd0);
    step();
  endtask

  initial begin
    reset = 1'b0;
    cmd_valid1 = 1'b0; cmd_op1 = '0; cmd_imm1 = '0; res_ready1 = 1'b1;
    cmd_valid3 = 1'b0; cmd_op3 = '0; cmd_imm3 = '0; res_ready3 = 1'b1;

    // Reset state, with a command presented during reset (dropped).
    step();
    cmd_valid1 = 1'b1; cmd_op1 = OP_LOAD; cmd_imm1 = 32'h55;
    step();
    cmd_valid1 = 1'b0;
    check("rst cmd_ready",  {31'd0, cmd_ready1}, 32'd1);
    check("rst res_valid",  {31'd0, res_valid1}, 32'd0);
    check("rst res_data",   res_data1, 32'd0);
    check("rst res_zero",   {31'd0, res_zero1}, 32'd1);
    check("rst res_ovf",    {31'd0, res_ovf1}, 32'd0);
    check("rst alu_A",      alu_A1, 32'd0);
    check("rst alu_B",      alu_B1, 32'd0);
    check("rst alu_control", {29'd0, alu_ctl1}, 32'd0);
    reset = 1'b1;
    step();
    check("post-rst res_valid", {31'd0, res_valid1}, 32'd0);

    // LOAD 5: result one cycle after handshake.
    send1(OP_LOAD, 32'h0000_0005);
    result1("load5", 32'd5, 1'b0);
    check("load5 back to idle", {31'd0, cmd_ready1}, 32'd1);

    // ADD 3: ALU driven for exactly one cycle, cmd_ready low for two.
    send1(OP_ADD, 32'd3);
    check("add3 exec alu_A", alu_A1, 32'd5);
    check("add3 exec alu_B", alu_B1, 32'd3);
    check("add3 exec alu_control", {29'd0, alu_ctl1}, {29'd0, OP_ADD});
    check("add3 exec cmd_ready", {31'd0, cmd_ready1}, 32'd0);
    check("add3 exec res_valid", {31'd0, res_valid1}, 32'd0);
    step();
    check("add3 done alu_control", {29'd0, alu_ctl1}, 32'd0);
    check("add3 done alu_A", alu_A1, 32'd0);
    result1("add3", 32'd8, 1'b0);

    // Signed overflow on ADD, then XOR keeps or clears it.
    send1(OP_LOAD, 32'h7FFF_FFFF); step();
    send1(OP_ADD, 32'd1); step();
    result1("add ovf", 32'h8000_0000, 1'b1);
    send1(OP_XOR, 32'h0000_000F); step();
    result1("xor after ovf", 32'h8000_000F, STICKY);

    // NOP after an overflowing ADD.
    send1(OP_LOAD, 32'h7FFF_FFFF); step();
    send1(OP_ADD, 32'd1); step();
    result1("add ovf2", 32'h8000_0000, 1'b1);
    send1(OP_NOP, 32'h1234_5678);
    result1("nop", 32'h8000_0000, STICKY);

    // SUB overflow, LOAD clears the flag.
    send1(OP_LOAD, 32'h8000_0000); step();
    send1(OP_SUB, 32'd1); step();
    result1("sub ovf", 32'h7FFF_FFFF, 1'b1);
    send1(OP_LOAD, 32'hFFFF_FFFF);
    result1("load clears ovf", 32'hFFFF_FFFF, 1'b0);

    // AND 0 -> zero result.
    send1(OP_AND, 32'd0); step();
    result1("and zero", 32'd0, 1'b0);

    // OR and NOR.
    send1(OP_LOAD, 32'h0000_00F0); step();
    send1(OP_OR, 32'h0000_000F); step();
    result1("or", 32'h0000_00FF, 1'b0);
    send1(OP_NOR, 32'd0); step();
    result1("nor", 32'hFFFF_FF00, 1'b0);

    // Back-pressure: hold res_ready low for 5 cycles in DONE.
    res_ready1 = 1'b0;
    send1(OP_LOAD, 32'h0000_1234);
    for (int i = 0; i < 5; i++) begin
      check("bp res_valid",  {31'd0, res_valid1}, 32'd1);
      check("bp res_data",   res_data1, 32'h0000_1234);
      check("bp cmd_ready",  {31'd0, cmd_ready1}, 32'd0);
      cmd_valid1 = (i == 2);
      cmd_op1    = OP_LOAD;
      cmd_imm1   = 32'h0000_DEAD;
      step();
    end
    cmd_valid1 = 1'b0;
    check("bp held res_data", res_data1, 32'h0000_1234);
    res_ready1 = 1'b1;
    step();
    check("bp release cmd_ready", {31'd0, cmd_ready1}, 32'd1);
    check("bp release res_valid", {31'd0, res_valid1}, 32'd0);
    check("bp pulse ignored",     res_data1, 32'h0000_1234);

    // ALU_LAT = 3: EXEC lasts three cycles.
    send3(OP_LOAD, 32'd10); step();
    send3(OP_ADD, 32'd20);
    for (int i = 0; i < 3; i++) begin
      check("lat3 exec alu_control", {29'd0, alu_ctl3}, {29'd0, OP_ADD});
      check("lat3 exec alu_A", alu_A3, 32'd10);
      check("lat3 exec res_valid", {31'd0, res_valid3}, 32'd0);
      step();
    end
    check("lat3 res_valid", {31'd0, res_valid3}, 32'd1);
    check("lat3 res_data",  res_data3, 32'd30);
    step();

    // Reset in the 2nd EXEC cycle aborts the command immediately.
    send3(OP_ADD, 32'd1);
    step();
    check("lat3 2nd exec alu_control", {29'd0, alu_ctl3}, {29'd0, OP_ADD});
    reset = 1'b0;
    #1;
    check("abort cmd_ready",   {31'd0, cmd_ready3}, 32'd1);
    check("abort res_valid",   {31'd0, res_valid3}, 32'd0);
    check("abort res_data",    res_data3, 32'd0);
    check("abort res_zero",    {31'd0, res_zero3}, 32'd1);
    check("abort res_ovf",     {31'd0, res_ovf3}, 32'd0);
    check("abort alu_A",       alu_A3, 32'd0);
    check("abort alu_B",       alu_B3, 32'd0);
    check("abort alu_control", {29'd0, alu_ctl3}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("after abort res_valid", {31'd0, res_valid3}, 32'd0);
    end
    send3(OP_LOAD, 32'd9);
    check("new cmd res_valid", {31'd0, res_valid3}, 32'd1);
    check("new cmd res_data",  res_data3, 32'd9);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Command sequencer for the MIPS calculator datapath, sitting directly upstream and downstream of the 32-bit ALU. It accepts one operation command at a time over a valid/ready handshake and holds a 32-bit accumulator. It drives the ALU with `A = accumulator` and `B = immediate`, captures the ALU result back into the accumulator after a fixed latency, and presents the result on a valid/ready output port.

## Interface
- `WIDTH`, 32, datapath width of accumulator, immediate and ALU operands.
- `ALU_LAT`, 1, cycles from ALU operands driven to `alu_out` being captured; legal range 1..15.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; `reset == 0` forces the reset state immediately.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  3  operation code (from `calc_pkg`).
- `cmd_imm`  in  WIDTH  immediate operand.
- `alu_A`  out  WIDTH  ALU operand A (accumulator).
- `alu_B`  out  WIDTH  ALU operand B (latched immediate).
- `alu_control`  out  3  ALU operation select.
- `alu_out`  in  WIDTH  ALU result.
- `alu_overflow`  in  1  ALU signed overflow for ADD/SUB.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  WIDTH  accumulator value after the command.
- `res_zero`  out  1  `res_data == 0`.
- `res_ovf`  out  1  overflow flag (see Configuration).

## Operation
- States: IDLE, EXEC, DONE. One command outstanding at a time; no queueing.
- IDLE:
  - `cmd_ready = 1`.
  - On `cmd_valid & cmd_ready`, latch `cmd_op` and `cmd_imm`.
  - LOAD: `acc <= cmd_imm`, ovf cleared, go to DONE.
  - NOP: acc unchanged, go to DONE.
  - ADD/SUB/AND/OR/NOR/XOR: go to EXEC with latency counter = `ALU_LAT`.
- EXEC:
  - `alu_A = acc`, `alu_B = imm_q`, `alu_control = op_q`, held stable for the whole state.
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, capture `acc <= alu_out` and the overflow update, then go to DONE.
  - Overflow update: `alu_overflow` for ADD/SUB; 0 for logic ops.
- DONE:
  - `res_valid = 1`; `res_data = acc`; `res_zero = (acc == 0)`.
  - On `res_ready`, go to IDLE.
  - `res_*` outputs are held stable while `res_valid & !res_ready`.
- Outside EXEC: `alu_A`, `alu_B` and `alu_control` are driven 0.
- Unknown op codes (none remain in the 3-bit space) are not possible. Op code 001 (NOP) is never sent to the ALU.
- Arithmetic is WIDTH-bit wrap-around. The sequencer does no arithmetic itself.

## Timing
- Reset values:
  - state IDLE, `acc = 0`, ovf = 0, latched op/imm = 0.
  - `cmd_ready = 1`, `res_valid = 0`, `res_data = 0`, `res_zero = 1`, `res_ovf = 0`.
  - `alu_A`, `alu_B`, `alu_control` all 0.
- Commands presented while `reset == 0` are dropped.
- LOAD/NOP: handshake in cycle 0; `res_valid` from cycle 1.
- ALU op: handshake in cycle 0; EXEC for cycles 1..`ALU_LAT`; `res_valid` from cycle `ALU_LAT + 1`.
- Peak throughput is one command per `ALU_LAT + 2` cycles when `res_ready` is tied high.
  - DONE → IDLE takes one cycle.
  - `cmd_ready` is never high in the same cycle as `res_valid`.
- `cmd_ready` and `res_valid` are decoded from registered state only. There is no combinational path from `cmd_valid` or `res_ready` to any output.
- Reset asserted mid-EXEC or mid-DONE aborts the command. No result is produced and all state returns to reset values.

## Configuration
- `CALC_STICKY_OVF_EN` defined:
  - `res_ovf` is sticky. It is the OR of every ADD/SUB overflow since reset or the last LOAD.
  - Only reset or LOAD clears it.
- `CALC_STICKY_OVF_EN` undefined:
  - `res_ovf` reports only the overflow of the most recent command.
  - It is 0 after LOAD, NOP, or any logic op.

## Structure
- Package `calc_pkg`:
  - Op codes: `CMD_LOAD = 3'b000`, `CMD_NOP = 3'b001`, `ALU_ADD = 3'b010`, `ALU_SUB = 3'b011`, `ALU_AND = 3'b100`, `ALU_OR = 3'b101`, `ALU_NOR = 3'b110`, `ALU_XOR = 3'b111`.
  - FSM state encodings.
  - These op codes are shared with the ALU control decode.
- One sub-module: `calc_acc_reg`. It holds the accumulator, the ovf flag and the sticky-clear logic, with load and capture enables driven by the FSM.

## Test plan
- Reset, then LOAD `0x0000_0005` with `res_ready = 1` → `res_valid` one cycle later, `res_data = 5`, `res_zero = 0`, `res_ovf = 0`.
- LOAD 5, then ADD 3 with `ALU_LAT = 1` → `alu_A = 5`, `alu_B = 3`, `alu_control = 010` for exactly 1 cycle; `res_data = 8`; `cmd_ready` low for 2 cycles.
- LOAD `0x7FFF_FFFF`, ADD 1, then XOR `0x0F` → after ADD, `res_data = 0x8000_0000` and `res_ovf = 1`. After XOR, `res_data = 0x8000_000F`; `res_ovf` is 1 with `CALC_STICKY_OVF_EN` and 0 without.
- LOAD `0xFFFF_FFFF`, AND 0 → `res_data = 0`, `res_zero = 1`.
- Hold `res_ready = 0` for 5 cycles in DONE → `res_valid` and `res_data` stable, `cmd_ready = 0`, and a `cmd_valid` pulse is ignored. Releasing `res_ready` returns to IDLE the next cycle.
- `ALU_LAT = 3`: assert reset in the 2nd EXEC cycle → all outputs at reset values immediately; after release, `res_valid` stays 0 until a new command.
